// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters ps2_clk, deframes 11-bit frames,
// decodes E0/F0 prefixes into key events. Define PS2_ASCII_XLATE_EN for ASCII output.
module ps2_keyboard_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] char,
    output logic       char_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       enter_pressed,
    output logic       frame_err
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_BITS,
        RX_CHECK
    } rx_state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          dat_s;
    logic          flt_lvl;
    logic [FW-1:0] flt_cnt;
    logic          flt_flip;
    logic          fall;

    rx_state_t     state;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic [10:0]   frame;
    logic [TW-1:0] to_cnt;
    logic          frame_good;
    logic          byte_vld;
    logic [7:0]    byte_q;
    logic          brk;
    logic          ext;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // The level flips on the FILTER_LEN-th consecutive sample that disagrees with it.
    assign flt_flip = (clk_s != flt_lvl) && (flt_cnt == FLT_MAX);
    assign fall     = flt_flip && flt_lvl;

    always_ff @(posedge clk) begin
        if (reset) begin
            flt_lvl <= 1'b1;
            flt_cnt <= '0;
        end else if (clk_s == flt_lvl) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FLT_MAX) begin
            flt_lvl <= clk_s;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    // Start bit low, odd parity over data+parity, stop bit high.
    assign frame_good = (frame[0] == 1'b0) && (^frame[9:1] == 1'b1) && (frame[10] == 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RX_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            frame     <= '0;
            to_cnt    <= '0;
            byte_vld  <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    to_cnt <= '0;
                    if (fall) begin
                        shift   <= {dat_s, shift[9:1]};
                        bit_cnt <= 4'd1;
                        state   <= RX_BITS;
                    end
                end
                RX_BITS: begin
                    if (fall) begin
                        to_cnt <= '0;
                        if (bit_cnt == 4'd10) begin
                            frame   <= {dat_s, shift};
                            bit_cnt <= '0;
                            state   <= RX_CHECK;
                        end else begin
                            shift   <= {dat_s, shift[9:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (to_cnt == TO_MAX) begin
                        to_cnt    <= '0;
                        bit_cnt   <= '0;
                        frame_err <= 1'b1;
                        state     <= RX_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RX_CHECK: begin
                    to_cnt <= '0;
                    if (frame_good) begin
                        byte_vld <= 1'b1;
                        byte_q   <= frame[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                    // The complete frame is already latched, so an edge here can start the next one.
                    if (fall) begin
                        shift   <= {dat_s, shift[9:1]};
                        bit_cnt <= 4'd1;
                        state   <= RX_BITS;
                    end else begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    state   <= RX_IDLE;
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end
            endcase
        end
    end

`ifdef PS2_ASCII_XLATE_EN
    logic       xl_hit;
    logic [7:0] xl_char;

    always_comb begin
        xl_hit  = 1'b1;
        xl_char = 8'h00;
        case (byte_q)
            8'h1C: xl_char = 8'h61;
            8'h32: xl_char = 8'h62;
            8'h21: xl_char = 8'h63;
            8'h23: xl_char = 8'h64;
            8'h24: xl_char = 8'h65;
            8'h2B: xl_char = 8'h66;
            8'h34: xl_char = 8'h67;
            8'h33: xl_char = 8'h68;
            8'h43: xl_char = 8'h69;
            8'h3B: xl_char = 8'h6A;
            8'h42: xl_char = 8'h6B;
            8'h4B: xl_char = 8'h6C;
            8'h3A: xl_char = 8'h6D;
            8'h31: xl_char = 8'h6E;
            8'h44: xl_char = 8'h6F;
            8'h4D: xl_char = 8'h70;
            8'h15: xl_char = 8'h71;
            8'h2D: xl_char = 8'h72;
            8'h1B: xl_char = 8'h73;
            8'h2C: xl_char = 8'h74;
            8'h3C: xl_char = 8'h75;
            8'h2A: xl_char = 8'h76;
            8'h1D: xl_char = 8'h77;
            8'h22: xl_char = 8'h78;
            8'h35: xl_char = 8'h79;
            8'h1A: xl_char = 8'h7A;
            8'h45: xl_char = 8'h30;
            8'h16: xl_char = 8'h31;
            8'h1E: xl_char = 8'h32;
            8'h26: xl_char = 8'h33;
            8'h25: xl_char = 8'h34;
            8'h2E: xl_char = 8'h35;
            8'h36: xl_char = 8'h36;
            8'h3D: xl_char = 8'h37;
            8'h3E: xl_char = 8'h38;
            8'h46: xl_char = 8'h39;
            8'h29: xl_char = 8'h20;
            8'h5A: xl_char = 8'h0D;
            8'h66: xl_char = 8'h08;
            default: xl_hit = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            char          <= 8'h00;
            char_valid    <= 1'b0;
            is_break      <= 1'b0;
            is_extended   <= 1'b0;
            enter_pressed <= 1'b0;
            brk           <= 1'b0;
            ext           <= 1'b0;
        end else begin
            char_valid    <= 1'b0;
            enter_pressed <= 1'b0;
            if (frame_err) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (byte_vld) begin
                if (byte_q == 8'hE0) begin
                    ext <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    brk           <= 1'b0;
                    ext           <= 1'b0;
                    enter_pressed <= (byte_q == 8'h5A) && !brk;
`ifdef PS2_ASCII_XLATE_EN
                    if (!brk && xl_hit) begin
                        char_valid  <= 1'b1;
                        char        <= xl_char;
                        is_break    <= 1'b0;
                        is_extended <= ext;
                    end
`else
                    char_valid  <= 1'b1;
                    char        <= byte_q;
                    is_break    <= brk;
                    is_extended <= ext;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed test-plan frames plus random frames against a
// queue-based event model. Honours PS2_ASCII_XLATE_EN when defined.
module tb_ps2_keyboard_rx;

    localparam int TO   = 300;
    localparam int FL   = 4;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] char;
    logic       char_valid;
    logic       is_break;
    logic       is_extended;
    logic       enter_pressed;
    logic       frame_err;

    ps2_keyboard_rx #(
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .char         (char),
        .char_valid   (char_valid),
        .is_break     (is_break),
        .is_extended  (is_extended),
        .enter_pressed(enter_pressed),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ch;
        logic       brk;
        logic       ext;
        logic       ent;
    } ev_t;

    ev_t        exp_q[$];
    int         err_pending = 0;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;
    logic [7:0] held_c = 8'h00;
    logic       held_b = 1'b0;
    logic       held_e = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         n_valid = 0;
    int         n_err = 0;
    logic [7:0] obs_char = 8'h00;
    logic       obs_brk = 1'b0;
    logic       obs_ext = 1'b0;
    logic       obs_ent = 1'b0;

`ifdef PS2_ASCII_XLATE_EN
    localparam logic [7:0] C1C = 8'h61, C16 = 8'h31, C29 = 8'h20, C5A = 8'h0D;
    logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    function automatic logic [8:0] to_ascii(input logic [7:0] b);
        for (int i = 0; i < 26; i++)
            if (letters[i] == b) return {1'b1, 8'(8'h61 + i)};
        for (int i = 0; i < 10; i++)
            if (digits[i] == b) return {1'b1, 8'(8'h30 + i)};
        if (b == 8'h29) return {1'b1, 8'h20};
        if (b == 8'h5A) return {1'b1, 8'h0D};
        if (b == 8'h66) return {1'b1, 8'h08};
        return 9'h000;
    endfunction
`else
    localparam logic [7:0] C1C = 8'h1C, C16 = 8'h16, C29 = 8'h29, C5A = 8'h5A;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected-event model: what a frame should produce given the current prefix state.
    task automatic model_frame(input logic [7:0] b, input bit good);
        ev_t e;
        if (!good) begin
            err_pending++;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
`ifdef PS2_ASCII_XLATE_EN
            logic [8:0] x;
            x = to_ascii(b);
            if (!m_brk && x[8]) begin
                e = '{ch: x[7:0], brk: 1'b0, ext: m_ext, ent: (b == 8'h5A)};
                exp_q.push_back(e);
            end
`else
            e = '{ch: b, brk: m_brk, ext: m_ext, ent: (b == 8'h5A) && !m_brk};
            exp_q.push_back(e);
`endif
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    // bad: 0 good, 1 parity flipped, 2 stop bit low
    task automatic send_bits(input logic [7:0] b, input int bad_kind, input int nbits, input bit glitch);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        if (bad_kind == 1) f[9] = ~f[9];
        if (bad_kind == 2) f[10] = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (glitch) begin
                cyc(HALF / 2);
                ps2_clk = 1'b0;
                cyc(1);
                ps2_clk = 1'b1;
                cyc(HALF - HALF / 2 - 1);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b0;
            if (glitch) begin
                cyc(HALF / 2);
                ps2_clk = 1'b1;
                cyc(1);
                ps2_clk = 1'b0;
                cyc(HALF - HALF / 2 - 1);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(2 * HALF);
    endtask

    task automatic frame(input logic [7:0] b, input int bad_kind, input bit glitch);
        model_frame(b, bad_kind == 0);
        send_bits(b, bad_kind, 11, glitch);
        chk("drain_events", exp_q.size(), 0);
        chk("drain_errors", err_pending, 0);
    endtask

    task automatic do_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b1;
        cyc(3);
        chk("rst_char", char, 8'h00);
        chk("rst_valid", char_valid, 0);
        chk("rst_break", is_break, 0);
        chk("rst_ext", is_extended, 0);
        chk("rst_enter", enter_pressed, 0);
        chk("rst_err", frame_err, 0);
        exp_q.delete();
        err_pending = 0;
        m_brk = 1'b0;
        m_ext = 1'b0;
        reset = 1'b0;
        cyc(2);
    endtask

    always @(negedge clk) begin : compare
        ev_t e;
        if (reset) begin
            held_c = 8'h00;
            held_b = 1'b0;
            held_e = 1'b0;
        end else begin
            if (char_valid) begin
                n_valid++;
                obs_char = char;
                obs_brk  = is_break;
                obs_ext  = is_extended;
                obs_ent  = enter_pressed;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_char", char, e.ch);
                    chk("ev_break", is_break, e.brk);
                    chk("ev_ext", is_extended, e.ext);
                    chk("ev_enter", enter_pressed, e.ent);
                    held_c = e.ch;
                    held_b = e.brk;
                    held_e = e.ext;
                end
            end else begin
                chk("enter_without_valid", enter_pressed, 0);
                chk("hold_char", char, held_c);
                chk("hold_break", is_break, held_b);
                chk("hold_ext", is_extended, held_e);
            end
            if (frame_err) begin
                n_err++;
                if (err_pending == 0) chk("unexpected_err", 1, 0);
                else err_pending--;
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stim
        int v0;
        int e0;
        int r;
        int bk;
        logic [7:0] b;
        logic [7:0] pool[5] = '{8'h1C, 8'h16, 8'h29, 8'h66, 8'h45};

        do_reset();

        v0 = n_valid;
        frame(8'h1C, 0, 1'b0);
        chk("t1_count", n_valid - v0, 1);
        chk("t1_char", obs_char, C1C);
        chk("t1_break", obs_brk, 0);
        chk("t1_ext", obs_ext, 0);
        chk("t1_enter", obs_ent, 0);

        v0 = n_valid;
        frame(8'hF0, 0, 1'b0);
        frame(8'h5A, 0, 1'b0);
`ifdef PS2_ASCII_XLATE_EN
        chk("t2_count", n_valid - v0, 0);
`else
        chk("t2_count", n_valid - v0, 1);
        chk("t2_char", obs_char, 8'h5A);
        chk("t2_break", obs_brk, 1);
        chk("t2_enter", obs_ent, 0);
`endif

        v0 = n_valid;
        frame(8'hE0, 0, 1'b0);
        frame(8'h5A, 0, 1'b0);
        chk("t3_count", n_valid - v0, 1);
        chk("t3_char", obs_char, C5A);
        chk("t3_ext", obs_ext, 1);
        chk("t3_enter", obs_ent, 1);

        v0 = n_valid;
        e0 = n_err;
        frame(8'h1C, 1, 1'b0);
        chk("t4_err_count", n_err - e0, 1);
        chk("t4_no_valid", n_valid - v0, 0);
        frame(8'h16, 0, 1'b0);
        chk("t4_char", obs_char, C16);

        e0 = n_err;
        err_pending++;
        m_brk = 1'b0;
        m_ext = 1'b0;
        send_bits(8'h29, 0, 5, 1'b0);
        cyc(TO + 100);
        chk("t5_err_count", n_err - e0, 1);
        chk("t5_drain", err_pending, 0);
        v0 = n_valid;
        frame(8'h29, 0, 1'b0);
        chk("t5_count", n_valid - v0, 1);
        chk("t5_char", obs_char, C29);

        v0 = n_valid;
        e0 = n_err;
        frame(8'h1C, 0, 1'b1);
        chk("t6_glitch_count", n_valid - v0, 1);
        chk("t6_glitch_char", obs_char, C1C);
        chk("t6_glitch_err", n_err - e0, 0);

        send_bits(8'h1C, 0, 4, 1'b0);
        do_reset();
        v0 = n_valid;
        e0 = n_err;
        frame(8'h1C, 0, 1'b0);
        chk("t6_post_rst_count", n_valid - v0, 1);
        chk("t6_post_rst_char", obs_char, C1C);
        chk("t6_post_rst_err", n_err - e0, 0);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20) b = 8'hE0;
            else if (r < 40) b = 8'hF0;
            else if (r < 50) b = 8'h5A;
            else if (r < 65) b = pool[$urandom_range(0, 4)];
            else b = 8'($urandom_range(0, 255));
            bk = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
            frame(b, bk, ($urandom_range(0, 3) == 0));
        end

        cyc(50);
        chk("final_events", exp_q.size(), 0);
        chk("final_errors", err_pending, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
